// File: rtl/trap_sequencer.sv
// M-mode trap entry/exit sequencer: CSR writes for mepc/mcause/mtval, vector or mepc read, redirect.
// Optional mstatus stacking state enabled by defining MSTATUS_STACK_EN.
module trap_sequencer #(
    parameter int unsigned XLEN        = 32,
    parameter logic [11:0] CSR_MSTATUS = 12'h300,
    parameter logic [11:0] CSR_MTVEC   = 12'h305,
    parameter logic [11:0] CSR_MEPC    = 12'h341,
    parameter logic [11:0] CSR_MCAUSE  = 12'h342,
    parameter logic [11:0] CSR_MTVAL   = 12'h343
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_enable,
    input  logic [2:0]      trap_status,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_value,
    input  logic            csr_ready,
    input  logic [XLEN-1:0] csr_read_data,
    output logic [11:0]     csr_read_address,
    output logic            csr_write_enable,
    output logic [11:0]     csr_write_address,
    output logic [XLEN-1:0] csr_write_data,
    output logic            trap_done,
    output logic            pth_done_flush,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy
);

    localparam logic [2:0] TrapNone     = 3'b000;
    localparam logic [2:0] TrapEcall    = 3'b001;
    localparam logic [2:0] TrapEbreak   = 3'b010;
    localparam logic [2:0] TrapMret     = 3'b011;
    localparam logic [2:0] TrapMisInstr = 3'b100;
    localparam logic [2:0] TrapMisLoad  = 3'b101;
    localparam logic [2:0] TrapMisStore = 3'b110;
    localparam logic [2:0] TrapIllegal  = 3'b111;

`ifdef MSTATUS_STACK_EN
    typedef enum logic [2:0] {
        StIdle, StWrMepc, StWrMcause, StWrMtval, StRdMtvec, StRdMepc, StMstatus, StRedirect
    } state_e;
    localparam state_e StAfterRead = StMstatus;
`else
    typedef enum logic [2:0] {
        StIdle, StWrMepc, StWrMcause, StWrMtval, StRdMtvec, StRdMepc, StRedirect
    } state_e;
    localparam state_e StAfterRead = StRedirect;
`endif

    state_e          r_state;
    state_e          w_state_next;
    logic [2:0]      r_status;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_value;
    logic [XLEN-1:0] r_target;
    logic            w_load_trap;
    logic            w_load_target;
    logic [4:0]      w_cause_code;
    logic [XLEN-1:0] w_mcause;
    logic [XLEN-1:0] w_mtval;
    logic [XLEN-1:0] w_read_aligned;
    logic            w_unused;

    always_comb begin
        w_cause_code = 5'd0;
        case (r_status)
            TrapEcall:    w_cause_code = 5'd11;
            TrapEbreak:   w_cause_code = 5'd3;
            TrapMisInstr: w_cause_code = 5'd0;
            TrapMisLoad:  w_cause_code = 5'd4;
            TrapMisStore: w_cause_code = 5'd6;
            TrapIllegal:  w_cause_code = 5'd2;
            default:      w_cause_code = 5'd0;
        endcase
    end

    assign w_mcause       = {{(XLEN-5){1'b0}}, w_cause_code};
    // Environment-call traps carry no faulting value.
    assign w_mtval        = (r_status == TrapEcall || r_status == TrapEbreak) ? '0 : r_value;
    assign w_read_aligned = {csr_read_data[XLEN-1:2], 2'b00};
    assign w_unused       = ^{CSR_MSTATUS, r_pc[1:0], csr_read_data[1:0]};

`ifdef MSTATUS_STACK_EN
    logic [XLEN-1:0] w_mstatus_new;

    always_comb begin
        w_mstatus_new        = csr_read_data;
        w_mstatus_new[12:11] = 2'b11;
        if (r_status == TrapMret) begin
            w_mstatus_new[3] = csr_read_data[7];
            w_mstatus_new[7] = 1'b1;
        end else begin
            w_mstatus_new[7] = csr_read_data[3];
            w_mstatus_new[3] = 1'b0;
        end
    end
`endif

    always_comb begin
        w_state_next      = r_state;
        w_load_trap       = 1'b0;
        w_load_target     = 1'b0;
        csr_read_address  = '0;
        csr_write_enable  = 1'b0;
        csr_write_address = '0;
        csr_write_data    = '0;
        pth_done_flush    = 1'b0;
        redirect_pc       = '0;
        case (r_state)
            StIdle: begin
                if (trap_status != TrapNone) begin
                    w_load_trap  = 1'b1;
                    w_state_next = (trap_status == TrapMret) ? StRdMepc : StWrMepc;
                end
            end
            StWrMepc: begin
                csr_write_enable  = 1'b1;
                csr_write_address = CSR_MEPC;
                csr_write_data    = {r_pc[XLEN-1:2], 2'b00};
                if (csr_ready) w_state_next = StWrMcause;
            end
            StWrMcause: begin
                csr_write_enable  = 1'b1;
                csr_write_address = CSR_MCAUSE;
                csr_write_data    = w_mcause;
                if (csr_ready) w_state_next = StWrMtval;
            end
            StWrMtval: begin
                csr_write_enable  = 1'b1;
                csr_write_address = CSR_MTVAL;
                csr_write_data    = w_mtval;
                if (csr_ready) w_state_next = StRdMtvec;
            end
            StRdMtvec: begin
                csr_read_address = CSR_MTVEC;
                w_load_target    = 1'b1;
                w_state_next     = StAfterRead;
            end
            StRdMepc: begin
                csr_read_address = CSR_MEPC;
                w_load_target    = 1'b1;
                w_state_next     = StAfterRead;
            end
`ifdef MSTATUS_STACK_EN
            StMstatus: begin
                csr_read_address  = CSR_MSTATUS;
                csr_write_enable  = 1'b1;
                csr_write_address = CSR_MSTATUS;
                csr_write_data    = w_mstatus_new;
                if (csr_ready) w_state_next = StRedirect;
            end
`endif
            StRedirect: begin
                pth_done_flush = 1'b1;
                redirect_pc    = r_target;
                w_state_next   = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_status <= TrapNone;
            r_pc     <= '0;
            r_value  <= '0;
            r_target <= '0;
        end else if (clk_enable) begin
            r_state <= w_state_next;
            if (w_load_trap) begin
                r_status <= trap_status;
                r_pc     <= trap_pc;
                r_value  <= trap_value;
            end
            if (w_load_target) r_target <= w_read_aligned;
        end
    end

    // Stall asserts combinationally in the detection cycle; released during the redirect.
    assign trap_done = !((r_state != StIdle) || (trap_status != TrapNone)) ||
                       (r_state == StRedirect);
    assign busy      = (r_state != StIdle);

endmodule
